pixel_addr_sequencer: RTL and testbench
=======================================

Name: pixel_addr_sequencer

Overview:
Parametrised pixel-address sequencer for the median-filter datapath. It steps a pixel address once every PERIOD clocks and issues a one-cycle write strobe at a fixed phase within each pixel slot. It adds start/abort/stall control, single-frame or continuous-frame modes, and done/wrap status. It sits between the frame control logic and the pixel RAM write port.

Parameters:
- ADDR_W, 13, width of the pixel address.
- NUM_PIXELS, 8192, pixels per frame; legal range 1..2^ADDR_W.
- PERIOD, 11, clocks per pixel slot; must be at least 2.
- STROBE_AT, 9, slot phase whose *following* cycle carries oWrite; legal range 0..PERIOD-2.
- CONT_MODE, 0, selects the frame mode: 0 = stop after one frame, 1 = wrap and run continuously.
- CNT_W, $clog2(PERIOD), derived width of the phase counter; not for override.

Ports:
- iClk  in  1  clock; all logic is on the rising edge.
- iRst  in  1  reset; synchronous, active-high.
- iStart  in  1  start a frame; sampled only in IDLE.
- iAbort  in  1  abort the sequence; forces IDLE.
- iStall  in  1  freezes sequencing while high.
- oWrite  out  1  one-cycle write strobe, once per pixel.
- oAddrPixel  out  ADDR_W  current pixel address.
- oBusy  out  1  high while in RUN.
- oDone  out  1  one-cycle pulse at end of frame (single-frame mode only).
- oFrameWrap  out  1  one-cycle pulse on wrap (continuous mode only).

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, phase 0, oAddrPixel 0, and oWrite, oBusy, oDone, oFrameWrap all 0.
- States are IDLE and RUN.
- **IDLE**
  - When iStart=1 and iAbort=0: next cycle, state is RUN, phase 0, oAddrPixel 0, oBusy 1.
  - iAbort=1 has priority; with iAbort high, iStart is ignored.
- **RUN, iStall=0**
  - Phase increments each cycle.
  - When phase = PERIOD-1: phase returns to 0 and oAddrPixel increments.
- **RUN, iStall=1**
  - Phase and oAddrPixel hold.
  - oWrite is 0 in the next cycle.
- **Write strobe**
  - oWrite next = (state=RUN) and (phase=STROBE_AT) and !iStall.
  - The strobe is therefore high in the cycle where phase = STROBE_AT+1. The address still equals the pixel being written, because the increment happens only at PERIOD-1.
  - If iStall is asserted at phase STROBE_AT, the strobe is deferred to the first unstalled cycle. Exactly one strobe is issued per pixel.
- **End of frame** (oAddrPixel = NUM_PIXELS-1, phase = PERIOD-1, not stalled)
  - CONT_MODE=0: next cycle, state is IDLE, oDone=1 for one cycle, oBusy=0, oAddrPixel returns to 0.
  - CONT_MODE=1: oAddrPixel returns to 0, oFrameWrap=1 for one cycle, state stays RUN.
- **Address arithmetic**
  - Modulo NUM_PIXELS. The address never exceeds NUM_PIXELS-1, even when NUM_PIXELS < 2^ADDR_W.
- **iAbort in RUN**
  - Next cycle, state is IDLE, phase 0, oAddrPixel 0, oBusy 0, oWrite 0.
  - No oDone or oFrameWrap pulse, even if abort coincides with end of frame.
- **Other boundary rules**
  - iStart while in RUN is ignored.
  - iRst mid-frame returns every register to its reset value on the next edge.
- **Latency**
  - iStart sampled at cycle 0 gives the first strobe at cycle STROBE_AT+2.
  - A frame occupies NUM_PIXELS×PERIOD cycles of RUN, excluding stall cycles.

Optional Feature:
- Macro: PIXEL_SEQ_RASTER_XY_EN.
- **When defined**
  - Adds parameter IMG_W (default 128).
  - Adds outputs oCol [ADDR_W-1:0] and oRow [ADDR_W-1:0].
  - oCol and oRow are registered and updated in the same cycle as oAddrPixel, giving oAddrPixel = oRow×IMG_W + oCol.
  - When oCol = IMG_W-1, oCol returns to 0 and oRow increments.
  - oCol and oRow are cleared on reset, on abort, on frame end and on wrap.
  - No multiplier is permitted; the tracking is counter-based only.
- **When undefined:** the ports and logic are absent, and the interface is exactly as listed above.

Test Plan:
1. Reset, defaults, idle: hold iRst for 3 cycles, then release with no iStart for 20 cycles → all outputs 0 throughout.
2. Single frame (NUM_PIXELS=4, PERIOD=11, STROBE_AT=9): iStart at cycle 0 → oWrite high at cycles 11, 22, 33, 44, with oAddrPixel 0, 1, 2, 3 respectively; oDone high at cycle 45 only; oBusy high for cycles 1–44 inclusive and low from cycle 45.
3. Stall at the strobe phase: same configuration, iStall high during cycles 10–14 → the first oWrite moves to cycle 16; subsequent strobes shift by 5 cycles; still exactly 4 strobes in the frame.
4. Abort: iAbort at cycle 25 → at cycle 26, state IDLE, oAddrPixel 0, oBusy 0; no oDone; a new iStart restarts from address 0.
5. Continuous mode (CONT_MODE=1, NUM_PIXELS=3, PERIOD=4, STROBE_AT=1): run 30 cycles → oFrameWrap pulses every 12 cycles; addresses cycle 0, 1, 2, 0; oDone never asserts.
6. Raster build (PIXEL_SEQ_RASTER_XY_EN defined, IMG_W=3, NUM_PIXELS=6) → (oRow, oCol) sequence is (0,0), (0,1), (0,2), (1,0), (1,1), (1,2), and oRow×3+oCol = oAddrPixel on every cycle.

Source files
------------

// File: rtl/pixel_addr_sequencer.sv
// Pixel-address sequencer for the median-filter datapath.
// Steps a pixel address once every PERIOD clocks and issues a one-cycle
// write strobe at a fixed phase of each pixel slot, with start/abort/stall
// control, single-frame or continuous-frame modes and done/wrap status.
//
// Optional raster tracking (oCol/oRow, parameter IMG_W) is compiled in when
// the macro PIXEL_SEQ_RASTER_XY_EN is defined.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for iStart; phase and address parked at 0
// RUN   | stepping phase/address, strobing once per pixel slot
module pixel_addr_sequencer #(
  parameter int ADDR_W     = 13,
  parameter int NUM_PIXELS = 8192,
  parameter int PERIOD     = 11,
  parameter int STROBE_AT  = 9,
`ifdef PIXEL_SEQ_RASTER_XY_EN
  parameter int IMG_W      = 128,
`endif
  parameter int CONT_MODE  = 0
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic              iAbort,
  input  logic              iStall,
  output logic              oWrite,
  output logic [ADDR_W-1:0] oAddrPixel,
  output logic              oBusy,
  output logic              oDone,
`ifdef PIXEL_SEQ_RASTER_XY_EN
  output logic              oFrameWrap,
  output logic [ADDR_W-1:0] oCol,
  output logic [ADDR_W-1:0] oRow
`else
  output logic              oFrameWrap
`endif
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [CNT_W-1:0]  PH_LAST   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]  PH_STROBE = CNT_W'(STROBE_AT);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  phase, phase_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              write_nxt, busy_nxt, done_nxt, wrap_nxt;

`ifdef PIXEL_SEQ_RASTER_XY_EN
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 1);
  logic [ADDR_W-1:0] col_nxt, row_nxt;
`endif

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= IDLE;
      phase      <= '0;
      oAddrPixel <= '0;
      oWrite     <= 1'b0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oFrameWrap <= 1'b0;
`ifdef PIXEL_SEQ_RASTER_XY_EN
      oCol       <= '0;
      oRow       <= '0;
`endif
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      oAddrPixel <= addr_nxt;
      oWrite     <= write_nxt;
      oBusy      <= busy_nxt;
      oDone      <= done_nxt;
      oFrameWrap <= wrap_nxt;
`ifdef PIXEL_SEQ_RASTER_XY_EN
      oCol       <= col_nxt;
      oRow       <= row_nxt;
`endif
    end
  end

  // Next-state, phase/address stepping and pulse generation.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    addr_nxt  = oAddrPixel;
    write_nxt = 1'b0;
    done_nxt  = 1'b0;
    wrap_nxt  = 1'b0;
`ifdef PIXEL_SEQ_RASTER_XY_EN
    col_nxt   = oCol;
    row_nxt   = oRow;
`endif
    case (state)
      IDLE: begin
        if (iStart && !iAbort) begin
          state_nxt = RUN;
          phase_nxt = '0;
          addr_nxt  = '0;
`ifdef PIXEL_SEQ_RASTER_XY_EN
          col_nxt   = '0;
          row_nxt   = '0;
`endif
        end
      end
      RUN: begin
        if (iAbort) begin
          // Abort wins over everything, including a coinciding frame end.
          state_nxt = IDLE;
          phase_nxt = '0;
          addr_nxt  = '0;
`ifdef PIXEL_SEQ_RASTER_XY_EN
          col_nxt   = '0;
          row_nxt   = '0;
`endif
        end else if (!iStall) begin
          // A stall holds phase at STROBE_AT, so the strobe simply slips to
          // the first unstalled cycle and still fires once per pixel.
          write_nxt = (phase == PH_STROBE);
          if (phase == PH_LAST) begin
            phase_nxt = '0;
            if (oAddrPixel == ADDR_LAST) begin
              addr_nxt = '0;
`ifdef PIXEL_SEQ_RASTER_XY_EN
              col_nxt  = '0;
              row_nxt  = '0;
`endif
              if (CONT_MODE != 0) begin
                wrap_nxt = 1'b1;
              end else begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
              end
            end else begin
              addr_nxt = oAddrPixel + ADDR_W'(1);
`ifdef PIXEL_SEQ_RASTER_XY_EN
              if (oCol == COL_LAST) begin
                col_nxt = '0;
                row_nxt = oRow + ADDR_W'(1);
              end else begin
                col_nxt = oCol + ADDR_W'(1);
              end
`endif
            end
          end else begin
            phase_nxt = phase + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = '0;
        addr_nxt  = '0;
      end
    endcase
    busy_nxt = (state_nxt == RUN);
  end

endmodule

// File: tb/tb_pixel_addr_sequencer.sv
// Bench for pixel_addr_sequencer: one single-frame instance and one
// continuous-mode instance, compared every cycle against a reference that
// counts unstalled RUN cycles and derives pixel/phase by division.
module tb_pixel_addr_sequencer;

  localparam int S_N = 4, S_P = 11, S_SA = 9;
  localparam int C_N = 3, C_P = 4,  C_SA = 1;
  localparam int IMG_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_start = 0, s_abort = 0, s_stall = 0;
  logic c_start = 0, c_abort = 0, c_stall = 0;
  logic s_write, s_busy, s_done, s_wrap;
  logic c_write, c_busy, c_done, c_wrap;
  logic [12:0] s_addr, c_addr;
`ifdef PIXEL_SEQ_RASTER_XY_EN
  logic [12:0] s_col, s_row, c_col, c_row;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pixel_addr_sequencer #(
    .ADDR_W(13), .NUM_PIXELS(S_N), .PERIOD(S_P), .STROBE_AT(S_SA),
`ifdef PIXEL_SEQ_RASTER_XY_EN
    .IMG_W(IMG_W),
`endif
    .CONT_MODE(0)
  ) dut_s (
    .iClk(clk), .iRst(rst), .iStart(s_start), .iAbort(s_abort),
    .iStall(s_stall), .oWrite(s_write), .oAddrPixel(s_addr),
    .oBusy(s_busy), .oDone(s_done),
`ifdef PIXEL_SEQ_RASTER_XY_EN
    .oFrameWrap(s_wrap), .oCol(s_col), .oRow(s_row)
`else
    .oFrameWrap(s_wrap)
`endif
  );

  pixel_addr_sequencer #(
    .ADDR_W(13), .NUM_PIXELS(C_N), .PERIOD(C_P), .STROBE_AT(C_SA),
`ifdef PIXEL_SEQ_RASTER_XY_EN
    .IMG_W(IMG_W),
`endif
    .CONT_MODE(1)
  ) dut_c (
    .iClk(clk), .iRst(rst), .iStart(c_start), .iAbort(c_abort),
    .iStall(c_stall), .oWrite(c_write), .oAddrPixel(c_addr),
    .oBusy(c_busy), .oDone(c_done),
`ifdef PIXEL_SEQ_RASTER_XY_EN
    .oFrameWrap(c_wrap), .oCol(c_col), .oRow(c_row)
`else
    .oFrameWrap(c_wrap)
`endif
  );

  // Reference: k = unstalled RUN cycles since start; pixel = k/P, phase = k%P.
  typedef struct packed {
    logic        busy;
    logic [31:0] k;
    logic        wr;
    logic        done;
    logic        wrap;
  } mst_t;

  mst_t ms, mc;

  function automatic mst_t mnext(mst_t s, int n, int p, int sa, bit cont,
                                 bit r, bit start, bit abort, bit stall);
    mst_t o = s;
    o.wr = 0; o.done = 0; o.wrap = 0;
    if (r) begin
      o.busy = 0; o.k = 0;
    end else if (!s.busy) begin
      if (start && !abort) begin o.busy = 1; o.k = 0; end
    end else if (abort) begin
      o.busy = 0; o.k = 0;
    end else if (!stall) begin
      o.wr = ((s.k % p) == sa);
      if (s.k == n * p - 1) begin
        o.k = 0;
        if (cont) o.wrap = 1;
        else begin o.done = 1; o.busy = 0; end
      end else begin
        o.k = s.k + 1;
      end
    end
    return o;
  endfunction

  function automatic logic [12:0] maddr(mst_t s, int p);
    return s.busy ? 13'(s.k / p) : 13'd0;
  endfunction

  function automatic logic [31:0] pack(logic w, logic b, logic d, logic f,
                                       logic [12:0] a);
    return {15'd0, w, b, d, f, a};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the reference with the inputs seen at the edge,
  // then compare both instances at the falling edge.
  task automatic step();
    @(posedge clk);
    ms = mnext(ms, S_N, S_P, S_SA, 1'b0, rst, s_start, s_abort, s_stall);
    mc = mnext(mc, C_N, C_P, C_SA, 1'b1, rst, c_start, c_abort, c_stall);
    @(negedge clk);
    check_val("s_out", pack(s_write, s_busy, s_done, s_wrap, s_addr),
              pack(ms.wr, ms.busy, ms.done, ms.wrap, maddr(ms, S_P)));
    check_val("c_out", pack(c_write, c_busy, c_done, c_wrap, c_addr),
              pack(mc.wr, mc.busy, mc.done, mc.wrap, maddr(mc, C_P)));
`ifdef PIXEL_SEQ_RASTER_XY_EN
    check_val("s_xy", {3'd0, s_row, s_col},
              {3'd0, 13'(maddr(ms, S_P) / IMG_W), 13'(maddr(ms, S_P) % IMG_W)});
    check_val("c_xy", {3'd0, c_row, c_col},
              {3'd0, 13'(maddr(mc, C_P) / IMG_W), 13'(maddr(mc, C_P) % IMG_W)});
    check_val("s_xy_sum", 32'(s_row * IMG_W + s_col), 32'(s_addr));
`endif
  endtask

  int wr_cyc[$], wr_addr[$], done_cyc[$], wrap_cyc[$];
  int busy_n;

  task automatic clear_logs();
    wr_cyc.delete(); wr_addr.delete(); done_cyc.delete(); wrap_cyc.delete();
    busy_n = 0;
  endtask

  // Single-frame instance: iStart in cycle 0, optional stall window and abort.
  task automatic run_s(input int ncyc, input int st_lo, input int st_hi,
                       input int abort_at);
    clear_logs();
    for (int c = 0; c < ncyc; c++) begin
      s_start = (c == 0);
      s_stall = (c >= st_lo) && (c <= st_hi);
      s_abort = (c == abort_at);
      step();
      if (s_write) begin wr_cyc.push_back(c + 1); wr_addr.push_back(int'(s_addr)); end
      if (s_done) done_cyc.push_back(c + 1);
      if (s_busy) busy_n++;
      if (abort_at >= 0 && c == abort_at)
        check_val("t4_after_abort", {18'd0, s_busy, s_addr}, 32'd0);
    end
    s_start = 0; s_stall = 0; s_abort = 0;
  endtask

  task automatic check_strobes(input string tag, input int exp_cyc[4]);
    check_val({tag, "_nwr"}, wr_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_val({tag, "_wcyc"}, (i < wr_cyc.size()) ? wr_cyc[i] : -1, exp_cyc[i]);
      check_val({tag, "_waddr"}, (i < wr_addr.size()) ? wr_addr[i] : -1, i);
    end
  endtask

  initial begin
    int e2[4] = '{11, 22, 33, 44};
    int e3[4] = '{16, 27, 38, 49};
    int ca[7] = '{0, 1, 2, 0, 1, 2, 0};
    int pulses;
    ms = '0; mc = '0;
    @(negedge clk);

    // reset then idle
    rst = 1;
    for (int i = 0; i < 3; i++) step();
    rst = 0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      pulses += int'(s_write | s_busy | s_done | s_wrap | (s_addr != 0));
    end
    check_val("t1_idle_quiet", pulses, 0);

    // single frame
    run_s(50, -1, -1, -1);
    check_strobes("t2", e2);
    check_val("t2_ndone", done_cyc.size(), 1);
    check_val("t2_done_cyc", (done_cyc.size() > 0) ? done_cyc[0] : -1, 45);
    check_val("t2_busy_n", busy_n, 44);

    // stall across the strobe phase
    run_s(56, 10, 14, -1);
    check_strobes("t3", e3);
    check_val("t3_done_cyc", (done_cyc.size() > 0) ? done_cyc[0] : -1, 50);
    check_val("t3_busy_n", busy_n, 49);

    // abort, then restart from address 0
    run_s(60, -1, -1, 25);
    check_val("t4_ndone", done_cyc.size(), 0);
    check_val("t4_nwr", wr_cyc.size(), 2);
    run_s(50, -1, -1, -1);
    check_strobes("t4r", e2);

    // continuous mode
    clear_logs();
    for (int c = 0; c < 30; c++) begin
      c_start = (c == 0);
      step();
      if (c_write) wr_addr.push_back(int'(c_addr));
      if (c_wrap) wrap_cyc.push_back(c + 1);
      if (c_done) done_cyc.push_back(c + 1);
    end
    c_start = 0;
    check_val("t5_nwrap", wrap_cyc.size(), 2);
    check_val("t5_wrap0", (wrap_cyc.size() > 0) ? wrap_cyc[0] : -1, 13);
    check_val("t5_wrap1", (wrap_cyc.size() > 1) ? wrap_cyc[1] : -1, 25);
    check_val("t5_ndone", done_cyc.size(), 0);
    check_val("t5_nwr", wr_addr.size(), 7);
    for (int i = 0; i < 7; i++)
      check_val("t5_waddr", (i < wr_addr.size()) ? wr_addr[i] : -1, ca[i]);
    c_abort = 1;
    step();
    c_abort = 0;

    // randomized traffic on both instances, including mid-frame reset
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 399) == 0);
      s_start = ($urandom_range(0, 7) == 0);
      s_abort = ($urandom_range(0, 99) == 0);
      s_stall = ($urandom_range(0, 5) == 0);
      c_start = ($urandom_range(0, 7) == 0);
      c_abort = ($urandom_range(0, 149) == 0);
      c_stall = ($urandom_range(0, 4) == 0);
      step();
    end
    rst = 0; s_start = 0; s_abort = 0; s_stall = 0;
    c_start = 0; c_abort = 0; c_stall = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
